rv32v_mem_lane_sequencer: RTL and testbench
===========================================

// Module: rv32v_mem_lane_sequencer
// PURPOSE
// - Memory-stage consumer of the vector execute->memory bundle: takes one accepted load/store op with up to two
//   element lanes (addr = aluresult0/1, data = storedata0/1, lane enable = wen[1:0]) and serialises them onto
//   the single scalar data-memory port, lane 0 first.
// - Returns per-lane load data, aligned and zero-extended, with vd/woffset for vector register writeback.
//   Stalls execute while busy.
// PARAMETERS
// - ADDR_W  32  data-memory address width
// - DATA_W  32  data-memory word width; byte-lane math assumes 32
// PORTS
// - CLK            in   1   clock
// - RST            in   1   synchronous active-high reset
// - op_valid       in   1   execute offers an op; qualified by (load_ena|store_ena)
// - load_ena       in   1   op is a load
// - store_ena      in   1   op is a store; load_ena has priority if both set
// - wen            in   2   lane enables
// - aluresult0/1   in   32  lane 0/1 byte address
// - storedata0/1   in   32  lane 0/1 store element, right-justified
// - eew            in   sew_t  element width SEW8/16/32
// - vd             in   5   destination vreg, passed through
// - woffset0/1     in   offset_t  element offsets, passed through
// - flush          in   1   abort current op
// - op_ready       out  1   op accepted this cycle when op_valid & op_ready
// - dmem_ren       out  1   read request
// - dmem_wen       out  1   write request
// - dmem_addr      out  32  word-aligned address {addr[31:2],2'b00}
// - dmem_byte_en   out  4   byte strobes
// - dmem_wdata     out  32  store data replicated to the addressed byte lanes
// - dmem_busy      in   1   request not yet complete; hold outputs while high
// - dmem_rdata     in   32  read data, valid in the cycle dmem_busy is low
// - wb_valid       out  1   one-cycle pulse: op done
// - wb_wen         out  2   lanes that carry load data; 0 for stores
// - wb_data0/1     out  32  extracted load elements
// - wb_vd, wb_woffset0/1  out  held copies of vd/woffset
// - misaligned     out  1   exception pulse; present only with the feature enabled
// BEHAVIOUR
// - FSM states: IDLE, LANE0, LANE1, DONE. Reset or flush: go to IDLE.
//   On reset/flush, all outputs are 0 except op_ready=1.
// - IDLE: op_ready=1. On accept, capture all inputs. Next state:
//   LANE0 if wen[0]; else LANE1 if wen[1]; else DONE (no bus access).
// - LANE0/LANE1: drive ren/wen/addr/byte_en/wdata combinationally from the captured lane.
//   Hold them while dmem_busy=1.
//   On the first cycle with dmem_busy=0, complete the lane and capture read data for loads.
//   LANE0 then moves to LANE1 if wen[1], else to DONE. LANE1 moves to DONE.
// - DONE: wb_valid=1 for exactly one cycle, then IDLE. op_ready=0 in every state except IDLE.
// - Minimum latency with zero-wait memory:
//   - 2 lanes: accept at cycle t, wb_valid at t+3.
//   - 1 lane: wb_valid at t+2.
//   - wen=00: wb_valid at t+1.
// - Byte enables, with a = addr[1:0]:
//   - SEW8: 4'b0001<<a
//   - SEW16: 4'b0011<<{a[1],1'b0}
//   - SEW32: 4'hF
// - wdata replication:
//   - SEW8: {4{d[7:0]}}
//   - SEW16: {2{d[15:0]}}
//   - SEW32: d
// - Load extraction: take rdata >> (8*a) for SEW8 (using a) or SEW16 (using {a[1],0}), then mask
//   to 8/16 bits and zero-extend. SEW32 passes rdata unchanged.
// - Lanes that are not enabled leave wb_data at 0. wb_* outputs hold their values until the next DONE.
// - Flush in LANEx while dmem_busy=1: deassert requests the next cycle; the request is dropped and no wb_valid fires.
// - Flush takes priority over an accept in the same cycle; the op is not accepted.
// CONFIGURATION
// - RV32V_LSU_MISALIGN_CHECK_EN defined:
//   - Misaligned means SEW16 with a[0]=1, or SEW32 with a!=0.
//   - A misaligned enabled lane issues no bus access. FSM goes to DONE with wb_wen=0 and wb_valid=1.
//   - misaligned=1 in that DONE cycle. Lanes already completed are not undone.
// - Macro undefined: no misaligned port; low address bits are ignored for alignment
//   (SEW16 uses a[1], SEW32 uses word).
// TESTING
// - Load SEW32, wen=11, addr0=0x100, addr1=0x204, zero-wait, rdata 0xAABBCCDD then 0x11223344
//   -> two reads (addr 0x100 then 0x204, byte_en F), wb_valid at t+3, wb_data0=0xAABBCCDD,
//   wb_data1=0x11223344, wb_wen=11.
// - Store SEW8, wen=01, addr0=0x103, data0=0x5A -> one write: addr 0x100, byte_en 1000,
//   wdata 0x5A5A5A5A; wb_valid at t+2 with wb_wen=00.
// - Load SEW16, wen=10, addr1=0x42, dmem_busy high 3 cycles, rdata 0xBEEF1234
//   -> LANE0 skipped, request held 4 cycles, wb_data1=0x0000BEEF.
// - wen=00 store -> no dmem_ren/wen ever asserted; wb_valid at t+1; op_ready returns next cycle.
// - Flush during LANE1 with dmem_busy=1 -> requests drop next cycle, no wb_valid, op_ready=1.
//   A new op is accepted afterwards.
// - With RV32V_LSU_MISALIGN_CHECK_EN: SEW32 load, addr0=0x102 -> no bus access; wb_valid and
//   misaligned pulse together at t+2 with wb_wen=00.

Source files
------------

// File: rtl/rv32v_mem_lane_sequencer_if.sv
// Shared element types and the scalar data-memory port used by rv32v_mem_lane_sequencer.
// The sequencer drives the master side; the memory (or bench) drives the slave side.
package rv32v_mem_lane_sequencer_pkg;
  typedef enum logic [1:0] {SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2} sew_t;
  typedef logic [4:0] offset_t;
endpackage

interface rv32v_mem_lane_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  ren;
  logic                  wen;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     wdata;
  logic                  busy;
  logic [DATA_W-1:0]     rdata;

  modport master (output ren, wen, addr, byte_en, wdata, input busy, rdata);
  modport slave  (input ren, wen, addr, byte_en, wdata, output busy, rdata);
endinterface

// File: rtl/rv32v_mem_lane_sequencer.sv
// Serialises up to two vector element lanes of one load/store op onto a scalar data-memory port.
// Optional misalignment trap: define RV32V_LSU_MISALIGN_CHECK_EN.
module rv32v_mem_lane_sequencer
  import rv32v_mem_lane_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 op_valid,
  input  logic                 load_ena,
  input  logic                 store_ena,
  input  logic [1:0]           wen,
  input  logic [ADDR_W-1:0]    aluresult0,
  input  logic [ADDR_W-1:0]    aluresult1,
  input  logic [DATA_W-1:0]    storedata0,
  input  logic [DATA_W-1:0]    storedata1,
  input  sew_t                 eew,
  input  logic [4:0]           vd,
  input  offset_t              woffset0,
  input  offset_t              woffset1,
  input  logic                 flush,
  output logic                 op_ready,
  rv32v_mem_lane_sequencer_if.master dmem,
  output logic                 wb_valid,
  output logic [1:0]           wb_wen,
  output logic [DATA_W-1:0]    wb_data0,
  output logic [DATA_W-1:0]    wb_data1,
  output logic [4:0]           wb_vd,
  output offset_t              wb_woffset0,
  output offset_t              wb_woffset1
`ifdef RV32V_LSU_MISALIGN_CHECK_EN
  ,
  output logic                 misaligned
`endif
);

  typedef enum logic [1:0] {IDLE, LANE0, LANE1, DONE} state_t;

  state_t            state, state_d;
  logic              load_q;
  logic [1:0]        lanes_q;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic [DATA_W-1:0] data0_q, data1_q;
  sew_t              eew_q;
  logic [4:0]        vd_q;
  offset_t           woff0_q, woff1_q;
  logic [DATA_W-1:0] rd0_q, rd1_q, rd0_d, rd1_d;

  logic              accept, in_lane, lane_mis, issue, lane_done, lane_skip, enter_done;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data, ext;
  logic [1:0]        a;
  logic [4:0]        sh;

  always_comb begin
    op_ready  = (state == IDLE);
    accept    = op_valid & op_ready & (load_ena | store_ena) & ~flush;
    in_lane   = (state == LANE0) || (state == LANE1);
    cur_addr  = (state == LANE1) ? addr1_q : addr0_q;
    cur_data  = (state == LANE1) ? data1_q : data0_q;
    a         = cur_addr[1:0];
`ifdef RV32V_LSU_MISALIGN_CHECK_EN
    lane_mis  = ((eew_q == SEW16) && a[0]) || ((eew_q == SEW32) && (a != 2'b00));
`else
    lane_mis  = 1'b0;
`endif
    issue     = in_lane & ~lane_mis;
    lane_done = issue & ~dmem.busy & ~flush;
    lane_skip = in_lane & lane_mis & ~flush;

    dmem.ren  = issue & load_q;
    dmem.wen  = issue & ~load_q;
    dmem.addr = {cur_addr[ADDR_W-1:2], 2'b00};

    sh = '0;
    case (eew_q)
      SEW8: begin
        dmem.byte_en = 4'b0001 << a;
        dmem.wdata   = {4{cur_data[7:0]}};
        sh           = {a, 3'b000};
        ext          = (dmem.rdata >> sh) & DATA_W'(8'hFF);
      end
      SEW16: begin
        dmem.byte_en = 4'b0011 << {a[1], 1'b0};
        dmem.wdata   = {2{cur_data[15:0]}};
        sh           = {a[1], 4'b0000};
        ext          = (dmem.rdata >> sh) & DATA_W'(16'hFFFF);
      end
      default: begin
        dmem.byte_en = '1;
        dmem.wdata   = cur_data;
        ext          = dmem.rdata;
      end
    endcase

    rd0_d = rd0_q;
    rd1_d = rd1_q;
    if (lane_done && load_q) begin
      if (state == LANE1) rd1_d = ext;
      else                rd0_d = ext;
    end

    state_d = state;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:  if (accept) state_d = wen[0] ? LANE0 : (wen[1] ? LANE1 : DONE);
        LANE0: if (lane_skip) state_d = DONE;
               else if (lane_done) state_d = lanes_q[1] ? LANE1 : DONE;
        LANE1: if (lane_skip || lane_done) state_d = DONE;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    enter_done = (state_d == DONE) && (state != DONE);
    wb_valid   = (state == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      load_q      <= 1'b0;
      lanes_q     <= '0;
      addr0_q     <= '0;
      addr1_q     <= '0;
      data0_q     <= '0;
      data1_q     <= '0;
      eew_q       <= SEW8;
      vd_q        <= '0;
      woff0_q     <= '0;
      woff1_q     <= '0;
      rd0_q       <= '0;
      rd1_q       <= '0;
      wb_wen      <= '0;
      wb_data0    <= '0;
      wb_data1    <= '0;
      wb_vd       <= '0;
      wb_woffset0 <= '0;
      wb_woffset1 <= '0;
    end else begin
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
      if (accept) begin
        load_q  <= load_ena;
        lanes_q <= wen;
        addr0_q <= aluresult0;
        addr1_q <= aluresult1;
        data0_q <= storedata0;
        data1_q <= storedata1;
        eew_q   <= eew;
        vd_q    <= vd;
        woff0_q <= woffset0;
        woff1_q <= woffset1;
        rd0_q   <= '0;
        rd1_q   <= '0;
      end
      // An op with no lanes enters DONE straight from IDLE, so its tags come from the inputs.
      if (enter_done) begin
        if (state == IDLE) begin
          wb_wen      <= '0;
          wb_data0    <= '0;
          wb_data1    <= '0;
          wb_vd       <= vd;
          wb_woffset0 <= woffset0;
          wb_woffset1 <= woffset1;
        end else begin
          wb_wen      <= (load_q && !lane_skip) ? lanes_q : 2'b00;
          wb_data0    <= rd0_d;
          wb_data1    <= rd1_d;
          wb_vd       <= vd_q;
          wb_woffset0 <= woff0_q;
          wb_woffset1 <= woff1_q;
        end
      end
    end
  end

`ifdef RV32V_LSU_MISALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge CLK) begin
    if (RST || flush)   mis_q <= 1'b0;
    else if (accept)    mis_q <= 1'b0;
    else if (lane_skip) mis_q <= 1'b1;
  end

  assign misaligned = wb_valid & mis_q;
`endif

endmodule

// File: tb/tb_rv32v_mem_lane_sequencer.sv
// Scoreboard bench for rv32v_mem_lane_sequencer: directed ops, queued expectations, negedge monitors.
module tb_rv32v_mem_lane_sequencer;
  import rv32v_mem_lane_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, op_valid, load_ena, store_ena, flush, op_ready;
  logic [1:0]  wen;
  logic [31:0] aluresult0, aluresult1, storedata0, storedata1;
  sew_t        eew;
  logic [4:0]  vd, wb_vd;
  offset_t     woffset0, woffset1, wb_woffset0, wb_woffset1;
  logic        wb_valid;
  logic [1:0]  wb_wen;
  logic [31:0] wb_data0, wb_data1;
  logic        misaligned;

  rv32v_mem_lane_sequencer_if #(.ADDR_W(32), .DATA_W(32)) dmem_bus ();

  rv32v_mem_lane_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(clk), .RST(rst), .op_valid(op_valid), .load_ena(load_ena), .store_ena(store_ena),
    .wen(wen), .aluresult0(aluresult0), .aluresult1(aluresult1),
    .storedata0(storedata0), .storedata1(storedata1), .eew(eew), .vd(vd),
    .woffset0(woffset0), .woffset1(woffset1), .flush(flush), .op_ready(op_ready),
    .dmem(dmem_bus), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_data0(wb_data0),
    .wb_data1(wb_data1), .wb_vd(wb_vd), .wb_woffset0(wb_woffset0), .wb_woffset1(wb_woffset1)
`ifdef RV32V_LSU_MISALIGN_CHECK_EN
    , .misaligned(misaligned)
`endif
  );
`ifndef RV32V_LSU_MISALIGN_CHECK_EN
  assign misaligned = 1'b0;
`endif

  typedef struct {
    logic [1:0]  wen;
    logic [31:0] d0, d1;
    logic [4:0]  vd;
    offset_t     wo0, wo1;
    int          at;
    logic        mis;
  } wb_exp_t;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          hold;
  } bus_exp_t;

  wb_exp_t     wbq[$];
  bus_exp_t    busq[$];
  logic [31:0] rdq[$];
  int          mem_wait = 0;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  function automatic bus_exp_t mk_bus(input logic rd, input logic [31:0] addr, input logic [3:0] be,
                                      input logic [31:0] wdata, input int hold);
    bus_exp_t e;
    e.rd = rd; e.addr = addr; e.be = be; e.wdata = wdata; e.hold = hold;
    return e;
  endfunction

  function automatic wb_exp_t mk_wb(input logic [1:0] w, input logic [31:0] d0, input logic [31:0] d1,
                                    input logic [4:0] v, input offset_t o0, input offset_t o1, input logic mis);
    wb_exp_t e;
    e.wen = w; e.d0 = d0; e.d1 = d1; e.vd = v; e.wo0 = o0; e.wo1 = o1; e.at = 0; e.mis = mis;
    return e;
  endfunction

  // Memory model: completion observed at negedge, busy/rdata updated just after each posedge.
  logic mem_done = 1'b0, mem_rd = 1'b0;
  int   mcnt = 0;
  initial begin
    dmem_bus.busy  = 1'b0;
    dmem_bus.rdata = '0;
  end
  always @(negedge clk) begin
    mem_done = (dmem_bus.ren | dmem_bus.wen) & ~dmem_bus.busy;
    mem_rd   = dmem_bus.ren;
  end
  always @(posedge clk) begin
    #1;
    if (mem_done) begin
      mcnt = 0;
      if (mem_rd && rdq.size() > 0) void'(rdq.pop_front());
    end
    if (dmem_bus.ren | dmem_bus.wen) begin
      dmem_bus.busy  = (mcnt < mem_wait);
      mcnt++;
      dmem_bus.rdata = (rdq.size() > 0) ? rdq[0] : 32'h0;
    end else begin
      dmem_bus.busy  = 1'b0;
      dmem_bus.rdata = '0;
      mcnt = 0;
    end
  end

  int hold = 0;
  always @(negedge clk) begin
    bus_exp_t e;
    if (!rst) begin
      if (dmem_bus.ren | dmem_bus.wen) begin
        hold++;
        if (busq.size() == 0) fail_now("unexpected_req");
        else if (!dmem_bus.busy) begin
          e = busq.pop_front();
          chk("bus_ren",  32'(dmem_bus.ren), 32'(e.rd));
          chk("bus_wen",  32'(dmem_bus.wen), 32'(!e.rd));
          chk("bus_addr", dmem_bus.addr, e.addr);
          chk("bus_be",   32'(dmem_bus.byte_en), 32'(e.be));
          if (!e.rd) chk("bus_wdata", dmem_bus.wdata, e.wdata);
          chk("bus_hold", 32'(hold), 32'(e.hold));
          hold = 0;
        end
      end else begin
        hold = 0;
      end
    end
  end

  always @(negedge clk) begin
    wb_exp_t e;
    if (!rst && wb_valid) begin
      if (wbq.size() == 0) fail_now("unexpected_wb");
      else begin
        e = wbq.pop_front();
        chk("wb_cycle", 32'(cyc), 32'(e.at));
        chk("wb_wen",   32'(wb_wen), 32'(e.wen));
        chk("wb_data0", wb_data0, e.d0);
        chk("wb_data1", wb_data1, e.d1);
        chk("wb_vd",    32'(wb_vd), 32'(e.vd));
        chk("wb_woff0", 32'(wb_woffset0), 32'(e.wo0));
        chk("wb_woff1", 32'(wb_woffset1), 32'(e.wo1));
`ifdef RV32V_LSU_MISALIGN_CHECK_EN
        chk("wb_misaligned", 32'(misaligned), 32'(e.mis));
`endif
      end
    end
  end

  task automatic issue(input logic ld, input logic st, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input sew_t e,
                       input logic [4:0] v, input offset_t o0, input offset_t o1, input int lat);
    int guard = 0;
    @(negedge clk);
    while (!op_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!op_ready) fail_now("issue_timeout");
    load_ena = ld; store_ena = st; wen = w;
    aluresult0 = a0; aluresult1 = a1; storedata0 = d0; storedata1 = d1;
    eew = e; vd = v; woffset0 = o0; woffset1 = o1;
    op_valid = 1'b1;
    if (lat > 0 && wbq.size() > 0) wbq[wbq.size()-1].at = cyc + lat;
    @(negedge clk);
    op_valid = 1'b0; load_ena = 1'b0; store_ena = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((wbq.size() != 0 || busq.size() != 0 || !op_ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  initial begin
    #200000;
    fail_now("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; load_ena = 1'b0; store_ena = 1'b0; flush = 1'b0;
    wen = '0; aluresult0 = '0; aluresult1 = '0; storedata0 = '0; storedata1 = '0;
    eew = SEW8; vd = '0; woffset0 = '0; woffset1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_ren",      32'(dmem_bus.ren), 32'd0);
    chk("rst_wen",      32'(dmem_bus.wen), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data0", wb_data0, 32'd0);

    // Load SEW32, two lanes, zero-wait
    rdq.push_back(32'hAABBCCDD); rdq.push_back(32'h11223344);
    busq.push_back(mk_bus(1'b1, 32'h100, 4'hF, 32'h0, 1));
    busq.push_back(mk_bus(1'b1, 32'h204, 4'hF, 32'h0, 1));
    wbq.push_back(mk_wb(2'b11, 32'hAABBCCDD, 32'h11223344, 5'd7, 5'd3, 5'd4, 1'b0));
    issue(1'b1, 1'b0, 2'b11, 32'h100, 32'h204, 32'h0, 32'h0, SEW32, 5'd7, 5'd3, 5'd4, 3);
    drain();

    // Store SEW8, lane 0 only, unaligned byte
    busq.push_back(mk_bus(1'b0, 32'h100, 4'b1000, 32'h5A5A5A5A, 1));
    wbq.push_back(mk_wb(2'b00, 32'h0, 32'h0, 5'd2, 5'd1, 5'd0, 1'b0));
    issue(1'b0, 1'b1, 2'b01, 32'h103, 32'h0, 32'h1234565A, 32'h0, SEW8, 5'd2, 5'd1, 5'd0, 2);
    drain();

    // Load SEW16, lane 1 only, three busy cycles
    mem_wait = 3;
    rdq.push_back(32'hBEEF1234);
    busq.push_back(mk_bus(1'b1, 32'h40, 4'b1100, 32'h0, 4));
    wbq.push_back(mk_wb(2'b10, 32'h0, 32'h0000BEEF, 5'd9, 5'd0, 5'd1, 1'b0));
    issue(1'b1, 1'b0, 2'b10, 32'h999, 32'h42, 32'h0, 32'h0, SEW16, 5'd9, 5'd0, 5'd1, 5);
    drain();

    // Load SEW8 with store_ena also set (load wins), one wait per lane
    mem_wait = 1;
    rdq.push_back(32'h44332211); rdq.push_back(32'h88776655);
    busq.push_back(mk_bus(1'b1, 32'h0, 4'b0010, 32'h0, 2));
    busq.push_back(mk_bus(1'b1, 32'h4, 4'b1000, 32'h0, 2));
    wbq.push_back(mk_wb(2'b11, 32'h22, 32'h88, 5'd31, 5'd30, 5'd29, 1'b0));
    issue(1'b1, 1'b1, 2'b11, 32'h1, 32'h7, 32'h0, 32'h0, SEW8, 5'd31, 5'd30, 5'd29, 5);
    drain();
    mem_wait = 0;

    // Store SEW16, two lanes, upper and lower halves
    busq.push_back(mk_bus(1'b0, 32'h10, 4'b1100, 32'hCAFECAFE, 1));
    busq.push_back(mk_bus(1'b0, 32'h20, 4'b0011, 32'h56785678, 1));
    wbq.push_back(mk_wb(2'b00, 32'h0, 32'h0, 5'd4, 5'd6, 5'd8, 1'b0));
    issue(1'b0, 1'b1, 2'b11, 32'h12, 32'h20, 32'hFFFFCAFE, 32'h12345678, SEW16, 5'd4, 5'd6, 5'd8, 3);
    drain();

    // Store with no lanes enabled
    wbq.push_back(mk_wb(2'b00, 32'h0, 32'h0, 5'd3, 5'd5, 5'd6, 1'b0));
    issue(1'b0, 1'b1, 2'b00, 32'h300, 32'h304, 32'hFF, 32'hFF, SEW32, 5'd3, 5'd5, 5'd6, 1);
    chk("ready_in_done", 32'(op_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_done", 32'(op_ready), 32'd1);
    drain();

`ifdef RV32V_LSU_MISALIGN_CHECK_EN
    wbq.push_back(mk_wb(2'b00, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1));
    issue(1'b1, 1'b0, 2'b01, 32'h102, 32'h0, 32'h0, 32'h0, SEW32, 5'd1, 5'd2, 5'd3, 2);
    drain();
`else
    // Without the check, low address bits are ignored for SEW32
    rdq.push_back(32'h0BADF00D);
    busq.push_back(mk_bus(1'b1, 32'h100, 4'hF, 32'h0, 1));
    wbq.push_back(mk_wb(2'b01, 32'h0BADF00D, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0));
    issue(1'b1, 1'b0, 2'b01, 32'h102, 32'h0, 32'h0, 32'h0, SEW32, 5'd1, 5'd2, 5'd3, 2);
    drain();
`endif

    // Flush during a busy LANE1 request: request dropped, no writeback
    mem_wait = 5;
    rdq.push_back(32'hDEADBEEF);
    busq.push_back(mk_bus(1'b1, 32'h300, 4'hF, 32'h0, 1));
    issue(1'b1, 1'b0, 2'b10, 32'h0, 32'h300, 32'h0, 32'h0, SEW32, 5'd5, 5'd0, 5'd0, 0);
    chk("flush_pre_busy", 32'(dmem_bus.busy), 32'd1);
    chk("flush_pre_ren",  32'(dmem_bus.ren), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_drop_ren", 32'(dmem_bus.ren), 32'd0);
    chk("flush_ready",    32'(op_ready), 32'd1);
    busq.delete();
    rdq.delete();
    mem_wait = 0;
    repeat (4) @(negedge clk);

    // Flush wins over a simultaneous offer
    load_ena = 1'b1; wen = 2'b01; aluresult0 = 32'h500; eew = SEW32; op_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; load_ena = 1'b0; flush = 1'b0;
    chk("flushpri_ready", 32'(op_ready), 32'd1);
    chk("flushpri_ren",   32'(dmem_bus.ren), 32'd0);
    repeat (3) @(negedge clk);

    // New op accepted after the flush
    rdq.push_back(32'h01020304);
    busq.push_back(mk_bus(1'b1, 32'h80, 4'b0100, 32'h0, 1));
    wbq.push_back(mk_wb(2'b01, 32'h02, 32'h0, 5'd12, 5'd13, 5'd14, 1'b0));
    issue(1'b1, 1'b0, 2'b01, 32'h82, 32'h0, 32'h0, 32'h0, SEW8, 5'd12, 5'd13, 5'd14, 2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
